pipe_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX).

---
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the decode/execute datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_is_load;
    logic       ex_redirect;
    logic       ex_md_start;
    logic       md_done;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       md_timeout;
    logic [1:0] state_o;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_is_load,
               ex_redirect, ex_md_start, md_done,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, md_timeout, state_o
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_is_load,
               ex_redirect, ex_md_start, md_done,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, md_timeout, state_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for PC, IF/ID and ID/EX: load-use stall, redirect flush, MUL/DIV freeze.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles/flush_events performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MD_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StRun    = 2'd1,
        StMdBusy = 2'd2
    } state_e;

    localparam logic [3:0] InitLast = 4'(INIT_CYCLES - 1);
    localparam logic [9:0] MdLimit  = 10'(MD_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] init_cnt_q, init_cnt_d;
    logic [9:0] md_cnt_q, md_cnt_d;
    logic       md_timeout_q, md_timeout_d;

    logic load_use;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;

    assign load_use = hz.ex_is_load & hz.ex_reg_write & (hz.ex_rd != 5'd0) &
                      ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            init_cnt_q   <= '0;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;

        unique case (state_q)
            StInit: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (init_cnt_q == InitLast) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            StRun: begin
                if (hz.ex_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hz.ex_md_start && !hz.md_done) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    state_d  = StMdBusy;
                    md_cnt_d = 10'd1;
                end else if (load_use) begin
                    // One bubble into EX; the load leaves EX, so the stall lasts one cycle.
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            StMdBusy: begin
                // Completion takes precedence over a timeout in the same cycle.
                if (hz.md_done) begin
                    state_d  = StRun;
                    md_cnt_d = '0;
                end else if (md_cnt_q == MdLimit) begin
                    state_d      = StRun;
                    md_cnt_d     = '0;
                    md_timeout_d = 1'b1;
                end else begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    md_cnt_d = md_cnt_q + 10'd1;
                end
            end
            default: begin
                state_d     = StInit;
                init_cnt_d  = '0;
                md_cnt_d    = '0;
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        endcase
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.md_timeout  = md_timeout_q;
    assign hz.state_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;
    logic        stall_evt, flush_evt;

    assign stall_evt = !pc_en && (state_q == StRun || state_q == StMdBusy);
    assign flush_evt = (state_q == StRun) && hz.ex_redirect;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (flush_evt && flush_q != '1) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences and random stimulus
// checked against a cycle model; two instances differ only in MD_TIMEOUT.
module tb_pipe_hazard_ctrl;
    localparam int unsigned INIT_CYC = 2;
    localparam int unsigned TMO_A    = 8;
    localparam int unsigned TMO_B    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz_a ();
    pipe_hazard_ctrl_if hz_b ();

    assign hz_b.id_rs1       = hz_a.id_rs1;
    assign hz_b.id_rs2       = hz_a.id_rs2;
    assign hz_b.id_use_rs1   = hz_a.id_use_rs1;
    assign hz_b.id_use_rs2   = hz_a.id_use_rs2;
    assign hz_b.ex_rd        = hz_a.ex_rd;
    assign hz_b.ex_reg_write = hz_a.ex_reg_write;
    assign hz_b.ex_is_load   = hz_a.ex_is_load;
    assign hz_b.ex_redirect  = hz_a.ex_redirect;
    assign hz_b.ex_md_start  = hz_a.ex_md_start;
    assign hz_b.md_done      = hz_a.md_done;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
    longint      m_stall, m_flush;
`endif

    pipe_hazard_ctrl #(.INIT_CYCLES(INIT_CYC), .MD_TIMEOUT(TMO_A)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hz_a)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_a),
        .flush_events (flush_a)
`endif
    );

    pipe_hazard_ctrl #(.INIT_CYCLES(INIT_CYC), .MD_TIMEOUT(TMO_B)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hz_b)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_b),
        .flush_events (flush_b)
`endif
    );

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, md_timeout, state[1:0]}
    wire [7:0] out_a = {hz_a.pc_en, hz_a.if_id_en, hz_a.if_id_flush, hz_a.id_ex_en,
                        hz_a.id_ex_flush, hz_a.md_timeout, hz_a.state_o};
    wire [7:0] out_b = {hz_b.pc_en, hz_b.if_id_en, hz_b.if_id_flush, hz_b.id_ex_en,
                        hz_b.id_ex_flush, hz_b.md_timeout, hz_b.state_o};

    localparam logic [4:0] P_INIT = 5'b00111;
    localparam logic [4:0] P_FREE = 5'b11010;
    localparam logic [4:0] P_FRZ  = 5'b00000;
    localparam logic [4:0] P_BUB  = 5'b00011;
    localparam logic [4:0] P_RDR  = 5'b11111;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: remaining init cycles, busy flag with elapsed busy cycles, pending timeout pulse.
    int m_init[2];
    bit m_busy[2];
    int m_cyc[2];
    bit m_tmo[2];
    int tmo_lim[2];

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic [6:0] flags;  // {use1, use2, reg_write, is_load, redirect, md_start, md_done}
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkvec(string n, int r1, int r2, int rd, logic [6:0] f,
                                   logic [4:0] e);
        vec_t v;
        v.name = n; v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.rd = 5'(rd); v.flags = f; v.exp = e;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        return hz_a.ex_is_load && hz_a.ex_reg_write && hz_a.ex_rd != 0 &&
               ((hz_a.id_use_rs1 && hz_a.id_rs1 == hz_a.ex_rd) ||
                (hz_a.id_use_rs2 && hz_a.id_rs2 == hz_a.ex_rd));
    endfunction

    function automatic logic [7:0] model_out(int k);
        logic [4:0] p;
        logic [1:0] st;
        if (m_init[k] > 0) begin
            p = P_INIT; st = 2'd0;
        end else if (m_busy[k]) begin
            st = 2'd2;
            p  = (hz_a.md_done || m_cyc[k] == tmo_lim[k]) ? P_FREE : P_FRZ;
        end else begin
            st = 2'd1;
            if (hz_a.ex_redirect) p = P_RDR;
            else if (hz_a.ex_md_start && !hz_a.md_done) p = P_FRZ;
            else if (model_load_use()) p = P_BUB;
            else p = P_FREE;
        end
        return {p, m_tmo[k], st};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_init[k] = INIT_CYC; m_busy[k] = 0; m_cyc[k] = 0; m_tmo[k] = 0;
        end
`ifdef HAZARD_PERF_CNT_EN
        m_stall = 0; m_flush = 0;
`endif
    endfunction

    function automatic void model_tick(int k);
`ifdef HAZARD_PERF_CNT_EN
        logic [7:0] o;
        o = model_out(k);
        if (k == 0 && o[7] == 1'b0 && o[1:0] != 2'd0) m_stall++;
        if (k == 0 && o[1:0] == 2'd1 && hz_a.ex_redirect) m_flush++;
`endif
        m_tmo[k] = 0;
        if (m_init[k] > 0) m_init[k]--;
        else if (m_busy[k]) begin
            if (hz_a.md_done) m_busy[k] = 0;
            else if (m_cyc[k] == tmo_lim[k]) begin m_busy[k] = 0; m_tmo[k] = 1; end
            else m_cyc[k]++;
        end else if (!hz_a.ex_redirect && hz_a.ex_md_start && !hz_a.md_done) begin
            m_busy[k] = 1; m_cyc[k] = 1;
        end
    endfunction

    // Inputs are stable from posedge+1; outputs are checked at the negedge, model ticks at posedge.
    task automatic step(string name, bit use_exp, logic [4:0] exp5);
        @(negedge clk);
        check({name, "/a"}, out_a, model_out(0));
        check({name, "/b"}, out_b, model_out(1));
        if (use_exp) check({name, "/tbl"}, {3'b0, out_a[7:3]}, {3'b0, exp5});
        @(posedge clk);
        model_tick(0);
        model_tick(1);
        #1;
    endtask

    task automatic set_idle();
        hz_a.id_rs1 = '0; hz_a.id_rs2 = '0; hz_a.id_use_rs1 = 0; hz_a.id_use_rs2 = 0;
        hz_a.ex_rd = '0; hz_a.ex_reg_write = 0; hz_a.ex_is_load = 0; hz_a.ex_redirect = 0;
        hz_a.ex_md_start = 0; hz_a.md_done = 0;
    endtask

    task automatic apply_vec(vec_t v);
        hz_a.id_rs1 = v.rs1; hz_a.id_rs2 = v.rs2; hz_a.ex_rd = v.rd;
        {hz_a.id_use_rs1, hz_a.id_use_rs2, hz_a.ex_reg_write, hz_a.ex_is_load,
         hz_a.ex_redirect, hz_a.ex_md_start, hz_a.md_done} = v.flags;
    endtask

    // Asynchronous assertion mid-cycle; release just after a rising edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async/a", out_a, model_out(0));
        check("rst_async/b", out_b, model_out(1));
        @(posedge clk);
        #1;
        check("rst_hold/b", out_b, {P_INIT, 1'b0, 2'd0});
        rst_n = 1'b1;
    endtask

    int pulses;

    initial begin
        tmo_lim[0] = TMO_A;
        tmo_lim[1] = TMO_B;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", out_a, {P_INIT, 1'b0, 2'd0});
        rst_n = 1'b1;

        // Reset release: two frozen/flushed cycles, then RUN with everything enabled.
        step("init0", 1, P_INIT);
        step("init1", 1, P_INIT);
        check("run_state", {6'b0, hz_a.state_o}, 8'd1);
        step("run0", 1, P_FREE);

        vecs[0]  = mkvec("idle",        0, 0, 0, 7'b0000000, P_FREE);
        vecs[1]  = mkvec("lu_rs2",      0, 5, 5, 7'b0111000, P_BUB);
        vecs[2]  = mkvec("after_lu",    0, 5, 5, 7'b0110000, P_FREE);
        vecs[3]  = mkvec("lu_rd0",      0, 0, 0, 7'b0111000, P_FREE);
        vecs[4]  = mkvec("lu_nouse",    0, 5, 5, 7'b0011000, P_FREE);
        vecs[5]  = mkvec("lu_rs1",      9, 1, 9, 7'b1011000, P_BUB);
        vecs[6]  = mkvec("lu_nowrite",  9, 1, 9, 7'b1001000, P_FREE);
        vecs[7]  = mkvec("rdr_lu",      0, 5, 5, 7'b0111100, P_RDR);
        vecs[8]  = mkvec("rdr",         0, 0, 3, 7'b0000100, P_RDR);
        vecs[9]  = mkvec("md_same_cyc", 0, 0, 0, 7'b0000011, P_FREE);
        vecs[10] = mkvec("rdr_md",      0, 0, 0, 7'b0000110, P_RDR);
        vecs[11] = mkvec("lu_md_done", 31, 4, 31, 7'b1011011, P_BUB);
        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            step(vecs[i].name, 1, vecs[i].exp);
        end
        set_idle();
        step("idle2", 1, P_FREE);

        // MD op completing on the 6th cycle; redirect and load-use mid-busy ignored.
        hz_a.ex_md_start = 1;
        step("md_start", 1, P_FRZ);
        for (int i = 1; i <= 4; i++) begin
            hz_a.ex_redirect = (i == 2);
            hz_a.ex_is_load = (i == 3); hz_a.ex_reg_write = 1; hz_a.ex_rd = 7;
            hz_a.id_rs1 = 7; hz_a.id_use_rs1 = 1;
            step("md_busy", 1, P_FRZ);
        end
        set_idle();
        hz_a.ex_md_start = 1; hz_a.md_done = 1;
        step("md_done", 1, P_FREE);
        set_idle();
        step("md_after", 1, P_FREE);
        check("md_back_run", {6'b0, hz_a.state_o}, 8'd1);

        // Timeout on the MD_TIMEOUT=4 instance: exactly one md_timeout pulse.
        hz_a.ex_md_start = 1;
        step("tmo_start", 0, '0);
        set_idle();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step("tmo_wait", 0, '0);
            pulses += int'(hz_b.md_timeout);
        end
        check("tmo_pulse_once", 8'(pulses), 8'd1);
        check("tmo_state_b", {6'b0, hz_b.state_o}, 8'd1);

        // Reset while MD_BUSY: back to INIT with no timeout pulse afterwards.
        hz_a.ex_md_start = 1;
        step("rst_md_start", 0, '0);
        set_idle();
        step("rst_md_busy", 0, '0);
        check("rst_md_in_busy", {6'b0, hz_b.state_o}, 8'd2);
        do_reset();
        check("rst_md_state", {6'b0, hz_b.state_o}, 8'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step("rst_md_after", 0, '0);
            pulses += int'(hz_b.md_timeout);
        end
        check("rst_md_no_tmo", 8'(pulses), 8'd0);

        // Random traffic against the model, with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            hz_a.id_rs1       = 5'($urandom_range(0, 3));
            hz_a.id_rs2       = 5'($urandom_range(0, 3));
            hz_a.ex_rd        = 5'($urandom_range(0, 3));
            hz_a.id_use_rs1   = 1'($urandom_range(0, 1));
            hz_a.id_use_rs2   = 1'($urandom_range(0, 1));
            hz_a.ex_reg_write = 1'($urandom_range(0, 1));
            hz_a.ex_is_load   = 1'($urandom_range(0, 1));
            hz_a.ex_redirect  = ($urandom_range(0, 7) == 0);
            hz_a.ex_md_start  = ($urandom_range(0, 9) == 0);
            hz_a.md_done      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            step("rand", 0, '0);
        end

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        check("perf_stall", stall_a[7:0], 8'(m_stall));
        check("perf_flush", flush_a[7:0], 8'(m_flush));
        check("perf_stall_hi", stall_a[31:24], 8'(m_stall >> 24));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
